// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared constants and types for the sign-merge receive aligner
package merge_pkg;

    localparam int MERGE_WIDTH   = 32;
    localparam int MERGE_PAD_MAX = 4;

    // Which source feeds the FIFO write port this cycle
    typedef enum logic [1:0] {
        WSEL_NONE  = 2'd0,
        WSEL_SHORT = 2'd1,
        WSEL_LONG  = 2'd2
    } wsel_t;

endpackage

// File: rtl/merge_rx_fifo.sv
// rtl/merge_rx_fifo.sv - synchronous FIFO with wrapping pointers and separate count
module merge_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle
    assign do_push   = push & (~full | do_pop);
    assign overflow  = push & full & ~do_pop;
    assign head_data = mem[head];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/merge_rx.sv
// rtl/merge_rx.sv - short/long path latency aligner with output FIFO (optional MERGE_RX_STATS_EN adds rx_count)
module merge_rx
    import merge_pkg::*;
#(
    parameter int WIDTH = MERGE_WIDTH,
    parameter int PAD   = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_long,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       err_collide,
    output logic                       err_overflow,
`ifdef MERGE_RX_STATS_EN
    output logic [31:0]                rx_count,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    logic [PAD-1:0]   pad_valid;
    logic [WIDTH-1:0] pad_data [PAD];
    logic             tail_valid;
    logic [WIDTH-1:0] tail_data;
    logic             long_valid;

    wsel_t            wsel;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             collide;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;
    logic             pop;

    assign tail_valid = pad_valid[PAD-1];
    assign tail_data  = pad_data[PAD-1];
    assign long_valid = in_valid & in_long;

    // Pad-stage valid bits: short results enter at stage 0, everything in flight dies on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_valid <= '0;
        end else begin
            pad_valid[0] <= in_valid & ~in_long;
            for (int i = 1; i < PAD; i++) begin
                pad_valid[i] <= pad_valid[i-1];
            end
        end
    end

    // Pad-stage data travels alongside the valid bits; only the valid bits need clearing
    always_ff @(posedge clk) begin
        pad_data[0] <= in_data;
        for (int i = 1; i < PAD; i++) begin
            pad_data[i] <= pad_data[i-1];
        end
    end

    // Write select: the delayed short result owns the write port, a colliding long result is lost
    always_comb begin
        wsel    = WSEL_NONE;
        wr_data = '0;
        collide = 1'b0;
        if (tail_valid) begin
            wsel    = WSEL_SHORT;
            wr_data = tail_data;
            collide = long_valid;
        end else if (long_valid) begin
            wsel    = WSEL_LONG;
            wr_data = in_data;
        end
    end

    assign wr_en = (wsel != WSEL_NONE);
    assign pop   = out_valid & out_ready;

    merge_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (level),
        .overflow  (fifo_overflow)
    );

    assign out_valid = ~fifo_empty;

    // Sticky protocol-violation flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_collide  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (collide) begin
                err_collide <= 1'b1;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef MERGE_RX_STATS_EN
    logic push_ok;

    // Same acceptance rule as the FIFO: dropped results are never counted
    assign push_ok = wr_en & (~fifo_full | pop);

    // Count of results actually stored, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count <= '0;
        end else if (push_ok) begin
            rx_count <= rx_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_merge_rx.sv
// tb/tb_merge_rx.sv - scoreboard bench for merge_rx (PAD=1, DEPTH=4)
module tb_merge_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_long;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        err_collide;
    logic        err_overflow;
    logic [2:0]  level;
`ifdef MERGE_RX_STATS_EN
    logic [31:0] rx_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    merge_rx #(.WIDTH(32), .PAD(1), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_long      (in_long),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err_collide  (err_collide),
        .err_overflow (err_overflow),
`ifdef MERGE_RX_STATS_EN
        .rx_count     (rx_count),
`endif
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_long  = 1'b0;
        in_data  = '0;
    endtask

    task automatic send(input logic is_long, input logic [31:0] d);
        in_valid = 1'b1;
        in_long  = is_long;
        in_data  = d;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        step();
        step();
    endtask

    // Monitor: every accepted output is compared against the next expected result
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %h expected none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_ready = 1'b0;
        reset_dut();
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err_collide", 32'(err_collide), 32'd0);
        chk("rst_err_overflow", 32'(err_overflow), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
`ifdef MERGE_RX_STATS_EN
        chk("rst_rx_count", rx_count, 32'd0);
`endif

        // Long then short, in order
        out_ready = 1'b1;
        send(1'b1, 32'hAAAA0001); exp_q.push_back(32'hAAAA0001); step();
        send(1'b0, 32'h55550002); exp_q.push_back(32'h55550002); step();
        idle();
        drain();

        // Short-path latency into an empty FIFO: visible two cycles after issue
        out_ready = 1'b0;
        send(1'b0, 32'h00000044); exp_q.push_back(32'h00000044); step();
        idle();
        chk("short_lat_cyc1_valid", 32'(out_valid), 32'd0);
        step();
        chk("short_lat_cyc2_valid", 32'(out_valid), 32'd1);
        chk("short_lat_cyc2_data", out_data, 32'h00000044);
        drain();

        // Collision: short 0x11 then long 0x22 land on the same write cycle
        send(1'b0, 32'h00000011); exp_q.push_back(32'h00000011); step();
        chk("collide_before", 32'(err_collide), 32'd0);
        send(1'b1, 32'h00000022); step();
        idle();
        chk("collide_set", 32'(err_collide), 32'd1);
        drain();
        chk("collide_sticky", 32'(err_collide), 32'd1);
        chk("collide_level", 32'(level), 32'd0);

        // Overflow: five longs into a 4-deep FIFO with no consumer
        reset_dut();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 32'(i));
            if (i <= 4) exp_q.push_back(32'(i));
            step();
        end
        idle();
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        chk("ovf_head", out_data, 32'd1);
        step();
        step();
        chk("ovf_head_stable", out_data, 32'd1);
        chk("ovf_err_sticky", 32'(err_overflow), 32'd1);
        drain();
        chk("ovf_drained_level", 32'(level), 32'd0);

        // Full FIFO with a simultaneous pop accepts the push
        reset_dut();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 32'h30 + 32'(i));
            exp_q.push_back(32'h30 + 32'(i));
            step();
        end
        idle();
        chk("full_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        send(1'b1, 32'h00000009); exp_q.push_back(32'h00000009); step();
        idle();
        out_ready = 1'b0;
        chk("full_pop_no_ovf", 32'(err_overflow), 32'd0);
        chk("full_pop_level", 32'(level), 32'd4);
        drain();

        // Mid-stream reset discards queued results
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 32'hC0 + 32'(i));
            step();
        end
        idle();
        chk("mid_level_pre", 32'(level), 32'd3);
`ifdef MERGE_RX_STATS_EN
        chk("mid_rx_count_pre", rx_count, 32'd8);
`endif
        rst = 1'b1;
        send(1'b1, 32'hDEADBEEF);
        step();
        rst = 1'b0;
        idle();
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
`ifdef MERGE_RX_STATS_EN
        chk("mid_rx_count", rx_count, 32'd0);
`endif
        step();
        chk("mid_ignored_input", 32'(level), 32'd0);
        send(1'b1, 32'h00000007); exp_q.push_back(32'h00000007); step();
        idle();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", out_data, 32'h00000007);
        chk("post_rst_level", 32'(level), 32'd1);
`ifdef MERGE_RX_STATS_EN
        chk("post_rst_rx_count", rx_count, 32'd1);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
